// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants, instruction classes and range limits shared by the instruction encoder.
package rv_isa_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [3:0] {
        CLS_LOAD   = 4'd0,
        CLS_STORE  = 4'd1,
        CLS_RTYPE  = 4'd2,
        CLS_BRANCH = 4'd3,
        CLS_ITYPE  = 4'd4,
        CLS_JAL    = 4'd5,
        CLS_AUIPC  = 4'd6,
        CLS_LUI    = 4'd7,
        CLS_JALR   = 4'd8
    } instrCls_e;

    typedef enum logic [1:0] {
        FIFO_EMPTY = 2'd0,
        FIFO_ONE   = 2'd1,
        FIFO_FULL  = 2'd2
    } fifoState_e;

    typedef struct packed {
        logic        err;
        logic [31:0] word;
    } encResult_t;

    localparam logic [31:0] NOP_WORD = 32'h00000013;

    localparam int IMM12_MIN = -2048;
    localparam int IMM12_MAX = 2047;
    localparam int IMM13_MIN = -4096;
    localparam int IMM13_MAX = 4094;
    localparam int IMM21_MIN = -(1 << 20);
    localparam int IMM21_MAX = (1 << 20) - 2;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry FIFO holding encoded words; head entry drives the outputs directly from registers.
module enc_fifo2
    import rv_isa_pkg::*;
#(
    parameter int W = 65
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic [W-1:0] pushData,
    input  logic         pop,
    output logic [W-1:0] headData,
    output logic         notEmpty,
    output logic         notFull
);

    fifoState_e   state;
    logic [W-1:0] head;
    logic [W-1:0] tail;

    // Entries only move from tail to head, so output order always matches push order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FIFO_EMPTY;
            head  <= '0;
            tail  <= '0;
        end else if (clear) begin
            state <= FIFO_EMPTY;
        end else begin
            case (state)
                FIFO_EMPTY: begin
                    if (push) begin
                        head  <= pushData;
                        state <= FIFO_ONE;
                    end
                end
                FIFO_ONE: begin
                    if (push && pop) begin
                        head <= pushData;
                    end else if (push) begin
                        tail  <= pushData;
                        state <= FIFO_FULL;
                    end else if (pop) begin
                        state <= FIFO_EMPTY;
                    end
                end
                FIFO_FULL: begin
                    if (pop) begin
                        head  <= tail;
                        state <= FIFO_ONE;
                    end
                end
                default: state <= FIFO_EMPTY;
            endcase
        end
    end

    assign headData = head;
    assign notEmpty = (state != FIFO_EMPTY);
    assign notFull  = (state != FIFO_FULL);

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I encoder: packs field requests into machine words tagged with sequential addresses.
// Optional immediate/funct7 legality checks are enabled by defining INSTR_ENC_RANGE_CHECK_EN.
module instr_encoder
    import rv_isa_pkg::*;
#(
    parameter int               ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              restart,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_cls,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rs1,
    input  logic [4:0]        req_rs2,
    input  logic [2:0]        req_funct3,
    input  logic [6:0]        req_funct7,
    input  logic [31:0]       req_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_err,
    output logic [7:0]        err_cnt
);

    localparam int ENTRY_W = 1 + ADDR_W + 32;

    function automatic encResult_t encode(
        input logic [3:0]  cls,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] imm
    );
        encResult_t r;
`ifdef INSTR_ENC_RANGE_CHECK_EN
        logic signed [31:0] sImm;
        sImm = $signed(imm);
`endif
        r.err  = 1'b0;
        r.word = NOP_WORD;
        case (cls)
            CLS_LOAD:   r.word = {imm[11:0], rs1, f3, rd, OP_LOAD};
            CLS_ITYPE:  r.word = {imm[11:0], rs1, f3, rd, OP_ITYPE};
            CLS_JALR:   r.word = {imm[11:0], rs1, 3'b000, rd, OP_JALR};
            CLS_STORE:  r.word = {imm[11:5], rs2, rs1, f3, imm[4:0], OP_STORE};
            CLS_RTYPE:  r.word = {f7, rs2, rs1, f3, rd, OP_RTYPE};
            CLS_BRANCH: r.word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], OP_BRANCH};
            CLS_LUI:    r.word = {imm[31:12], rd, OP_LUI};
            CLS_AUIPC:  r.word = {imm[31:12], rd, OP_AUIPC};
            CLS_JAL:    r.word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
            default:    r.err  = 1'b1;
        endcase
`ifdef INSTR_ENC_RANGE_CHECK_EN
        case (cls)
            CLS_LOAD, CLS_ITYPE, CLS_JALR, CLS_STORE:
                if (sImm < IMM12_MIN || sImm > IMM12_MAX) r.err = 1'b1;
            CLS_BRANCH:
                if (imm[0] || sImm < IMM13_MIN || sImm > IMM13_MAX) r.err = 1'b1;
            CLS_JAL:
                if (imm[0] || sImm < IMM21_MIN || sImm > IMM21_MAX) r.err = 1'b1;
            CLS_LUI, CLS_AUIPC:
                if (imm[11:0] != 12'd0) r.err = 1'b1;
            CLS_RTYPE:
                if (f7 != F7_BASE && f7 != F7_ALT) r.err = 1'b1;
            default: ;
        endcase
`endif
        if (r.err) r.word = NOP_WORD;
        return r;
    endfunction

    encResult_t        enc;
    logic              push;
    logic              pop;
    logic              fifoNotEmpty;
    logic              fifoNotFull;
    logic [ADDR_W-1:0] addrCnt;
    logic [7:0]        errCount;
    logic [ENTRY_W-1:0] headEntry;

    assign enc       = encode(req_cls, req_rd, req_rs1, req_rs2, req_funct3, req_funct7, req_imm);
    assign req_ready = fifoNotFull && !restart;
    assign push      = req_valid && req_ready;
    assign pop       = fifoNotEmpty && out_ready;

    // Every accepted request consumes an address, including substituted NOPs; wraps silently.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addrCnt <= BASE_ADDR;
        end else if (restart) begin
            addrCnt <= BASE_ADDR;
        end else if (push) begin
            addrCnt <= addrCnt + ADDR_W'(4);
        end
    end

    // Error count survives restart and saturates rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            errCount <= '0;
        end else if (push && enc.err && errCount != 8'hFF) begin
            errCount <= errCount + 8'd1;
        end
    end

    enc_fifo2 #(
        .W(ENTRY_W)
    ) uFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (restart),
        .push     (push),
        .pushData ({enc.err, addrCnt, enc.word}),
        .pop      (pop),
        .headData (headEntry),
        .notEmpty (fifoNotEmpty),
        .notFull  (fifoNotFull)
    );

    assign out_valid = fifoNotEmpty;
    assign out_err   = headEntry[ENTRY_W-1];
    assign out_addr  = headEntry[ENTRY_W-2 -: ADDR_W];
    assign out_data  = headEntry[31:0];
    assign err_cnt   = errCount;

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Streaming RV32I instruction encoder, the inverse of the core's main decoder. It accepts field-level instruction requests, packs them into 32-bit machine words using the format selected by the instruction class, and tags each word with a sequential instruction-memory address. Output goes through a 2-entry FIFO with a valid/ready handshake. It sits between the test/debug program loader and the instruction-memory write port.

## Interface
- `ADDR_W`, default 32: width of the emitted word address.
- `BASE_ADDR`, default 0: address of the first word after reset or restart. Must be 4-aligned.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `restart`  in  1  synchronous flush. Clears the FIFO and reloads the address to `BASE_ADDR`.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  encoder can accept a request.
- `req_cls`  in  4  instruction class: 0 LOAD, 1 STORE, 2 RTYPE, 3 BRANCH, 4 ITYPE, 5 JAL, 6 AUIPC, 7 LUI, 8 JALR. Values 9–15 are invalid.
- `req_rd`, `req_rs1`, `req_rs2`  in  5 each  register fields.
- `req_funct3`  in  3;  `req_funct7`  in  7.
- `req_imm`  in  32  signed byte offset or value. For U-type it is the full 32-bit value; bits [11:0] should be 0.
- `out_valid`  out  1;  `out_ready`  in  1.
- `out_data`  out  32  encoded word.
- `out_addr`  out  ADDR_W  word address.
- `out_err`  out  1  the word is an error substitute.
- `err_cnt`  out  8  count of errored requests, saturating at 255.

## Operation
- Opcodes: LOAD 0000011, STORE 0100011, RTYPE 0110011, BRANCH 1100011, ITYPE 0010011, JAL 1101111, AUIPC 0010111, LUI 0110111, JALR 1100111.
- Formats:
  - R: funct7 | rs2 | rs1 | f3 | rd | op.
  - I (LOAD, ITYPE, JALR): imm[11:0] | rs1 | f3 | rd | op. JALR forces f3 = 000.
  - S: imm[11:5] | rs2 | rs1 | f3 | imm[4:0] | op.
  - B: imm[12] | imm[10:5] | rs2 | rs1 | f3 | imm[4:1] | imm[11] | op.
  - U (LUI, AUIPC): imm[31:12] | rd | op.
  - J: imm[20] | imm[10:1] | imm[11] | imm[19:12] | rd | op.
- Fields not used by a format are ignored.
- An invalid class produces `out_data` = 0x00000013 (NOP), `out_err` = 1, and increments `err_cnt`.
- Address counter:
  - Starts at `BASE_ADDR`.
  - Each accepted request takes the current value, then the counter adds 4, modulo 2^ADDR_W (wraps silently).
  - Errored requests also consume an address.
- FIFO states: EMPTY, ONE, FULL.
  - Push on `req_valid && req_ready`; pop on `out_valid && out_ready`.
  - Push and pop in the same cycle from ONE stays in ONE.
  - `req_ready` = (state != FULL) && !`restart`. It is registered-state only; there is no combinational path from `out_ready`.
  - Output order equals acceptance order.
- `restart`:
  - Takes priority over push and pop in the same cycle.
  - Resulting state: EMPTY, address = `BASE_ADDR`. `err_cnt` is unchanged.
  - A request presented during `restart` is not accepted.
- Reset values: `out_valid` 0, `out_data` 0, `out_addr` 0, `out_err` 0, `err_cnt` 0, `req_ready` 1 (as soon as `rst_n` rises), address = `BASE_ADDR`.
- Reset asserted mid-stream drops all buffered words immediately.

## Timing
- Latency: a request accepted at edge N appears on `out_valid` after edge N (visible in cycle N+1), provided the FIFO was empty.
- Throughput: 1 word/cycle while `out_ready` = 1.
- `out_data`, `out_addr`, `out_err` are held stable while `out_valid && !out_ready`.
- `err_cnt` updates at the acceptance edge.

## Configuration
- `INSTR_ENC_RANGE_CHECK_EN` defined: additional checks at acceptance. Any failure gives a NOP substitute, `out_err` = 1, and increments `err_cnt`.
  - I/S immediates must be in [-2048, 2047].
  - B immediate must be even and in [-4096, 4094].
  - J immediate must be even and in [-2^20, 2^20-2].
  - U immediate bits [11:0] must be 0.
  - RTYPE `funct7` must be 0000000 or 0100000.
- Undefined: only the invalid-class check is performed. Immediates are truncated to the format bits and `funct7` is passed through.

## Structure
- Package `rv_isa_pkg` holds:
  - the opcode constants;
  - the class enum (4-bit);
  - the NOP constant 0x00000013;
  - the immediate range limits.
- The encoder is a combinational function inside `instr_encoder`.
- The buffer is sub-module `enc_fifo2`: a 2-entry FIFO carrying {err, addr, data}, with EMPTY/ONE/FULL state and synchronous clear.

## Test plan
- ITYPE, rd=1, rs1=0, f3=0, imm=5, after reset → `out_data` 0x00500093, `out_addr` = `BASE_ADDR`, `out_valid` in the next cycle.
- STORE, rs1=1, rs2=2, f3=2, imm=8 → 0x0020A423. BRANCH, rs1=rs2=0, f3=0, imm=-4 → 0xFE000EE3. LUI, rd=5, imm=0x12345000 → 0x123452B7.
- ITYPE, rd=1, imm=4096:
  - macro on → `out_data` 0x00000013, `out_err` = 1, `err_cnt` = 1.
  - macro off → 0x00000093, `out_err` = 0.
- `req_cls` = 12 → NOP with `out_err` = 1, and the address still advances by 4.
- `out_ready` = 0 with 3 back-to-back requests → `req_ready` drops after 2 accepts and the third is held. Releasing `out_ready` yields addresses BASE, BASE+4, BASE+8 in order.
- `restart` with FIFO FULL and `req_valid` high → FIFO empty and request not taken. The next accepted request gets `BASE_ADDR`. `rst_n` low mid-stream → all outputs reach their reset values asynchronously.
